// File: rtl/div64x32_seq.sv
// -----------------------------------------------------------------------------
// div64x32_seq -- sequential unsigned 64/32 divider (radix-2 restoring).
//
// One restoring step per clock on a 33-bit partial remainder. An operation
// occupies exactly 32 RUN cycles. The results are loaded on the final RUN
// edge and held until the final edge of the next accepted operation.
//
// Optional feature macro: DIV_ERR_CHECK_EN
//   defined   : divisor==0 or dividend[63:32] >= divisor is flagged. Such an
//               operation spends one RUN cycle only and returns
//               quotient=32'hFFFFFFFF, remainder=0, error=1.
//   undefined : error is always 0. Every operation takes 32 RUN cycles.
//               Results for operands that would overflow are unspecified.
//
// Ports:
//   clk       in   1  rising-edge clock
//   reset     in   1  asynchronous active-low reset (0 = in reset)
//   start     in   1  request a division (ignored while busy)
//   dividend  in  64  unsigned numerator, sampled with start
//   divisor   in  32  unsigned denominator, sampled with start
//   busy      out  1  operation in progress (state RUN)
//   quotient  out 32  quotient of the last completed operation
//   remainder out 32  remainder of the last completed operation
//   error     out  1  divide-by-zero / overflow flag of the last operation
// -----------------------------------------------------------------------------
module div64x32_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        error
);

    typedef enum logic [0:0] {
        IDLE_S = 1'b0,
        RUN_S  = 1'b1
    } state_e;

    state_e      state_q,  state_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [32:0] rem_q,    rem_d;     // partial remainder
    logic [31:0] dvd_q,    dvd_d;     // low dividend bits, shifted out as quotient bits shift in
    logic [31:0] dvs_q,    dvs_d;
    logic        err_op_q, err_op_d;  // current operation is a flagged one
    logic        busy_q,   busy_d;
    logic [31:0] quo_q,    quo_d;
    logic [31:0] rmd_q,    rmd_d;
    logic        error_q,  error_d;

    logic [32:0] shift_s;
    logic [33:0] diff_s;
    logic        fits_s;
    logic [32:0] rem_next_s;
    logic [31:0] quo_next_s;
    logic        op_bad_s;

`ifdef DIV_ERR_CHECK_EN
    assign op_bad_s = (divisor == 32'd0) || (dividend[63:32] >= divisor);
`else
    assign op_bad_s = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    // The partial remainder is always below the divisor, so bit 32 of rem_q is zero
    // and the shifted value fits in 33 bits; the extra top bit of diff_s is the borrow.
    always_comb begin
        shift_s    = {rem_q[31:0], dvd_q[31]};
        diff_s     = {1'b0, shift_s} - {2'b00, dvs_q};
        fits_s     = ~diff_s[33];
        rem_next_s = fits_s ? diff_s[32:0] : shift_s;
        quo_next_s = {dvd_q[30:0], fits_s};
    end

    // Next-state and datapath control for the IDLE/RUN sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        err_op_d = err_op_q;
        quo_d    = quo_q;
        rmd_d    = rmd_q;
        error_d  = error_q;
        case (state_q)
            IDLE_S: begin
                if (start) begin
                    state_d  = RUN_S;
                    cnt_d    = 5'd0;
                    rem_d    = {1'b0, dividend[63:32]};
                    dvd_d    = dividend[31:0];
                    dvs_d    = divisor;
                    err_op_d = op_bad_s;
                end else begin
                    state_d  = IDLE_S;
                end
            end
            RUN_S: begin
                if (err_op_q) begin
                    // Flagged operation: single RUN cycle, saturated result.
                    state_d  = IDLE_S;
                    err_op_d = 1'b0;
                    quo_d    = 32'hFFFF_FFFF;
                    rmd_d    = 32'd0;
                    error_d  = 1'b1;
                end else begin
                    rem_d = rem_next_s;
                    dvd_d = quo_next_s;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = IDLE_S;
                        quo_d   = quo_next_s;
                        rmd_d   = rem_next_s[31:0];
                        error_d = 1'b0;
                    end else begin
                        state_d = RUN_S;
                    end
                end
            end
            default: begin
                state_d = IDLE_S;
            end
        endcase
        busy_d = (state_d == RUN_S);
    end

    // State, working and result registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE_S;
            cnt_q    <= 5'd0;
            rem_q    <= 33'd0;
            dvd_q    <= 32'd0;
            dvs_q    <= 32'd0;
            err_op_q <= 1'b0;
            busy_q   <= 1'b0;
            quo_q    <= 32'd0;
            rmd_q    <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            err_op_q <= err_op_d;
            busy_q   <= busy_d;
            quo_q    <= quo_d;
            rmd_q    <= rmd_d;
            error_q  <= error_d;
        end
    end

    assign busy      = busy_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign error     = error_q;

endmodule

// File: tb/tb_div64x32_seq.sv
// -----------------------------------------------------------------------------
// tb_div64x32_seq -- self-checking bench for div64x32_seq.
// Expected results come from a reference model (64-bit / and %) plus the
// literal values of the known vectors; they are queued when an operation is
// launched and popped when the divider drops busy.
// -----------------------------------------------------------------------------
module tb_div64x32_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        error;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    div64x32_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .quotient  (quotient),
        .remainder (remainder),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: pushes the expected outcome of one operation.
    task automatic push_model(input logic [63:0] dd, input logic [31:0] ds);
        exp_t e;
        logic [63:0] q64;
        logic [63:0] r64;
`ifdef DIV_ERR_CHECK_EN
        if (ds == 32'd0 || dd[63:32] >= ds) begin
            e.q = 32'hFFFF_FFFF; e.r = 32'd0; e.e = 1'b1; e.cyc = 1;
            sb.push_back(e);
            return;
        end
`endif
        q64 = dd / {32'd0, ds};
        r64 = dd % {32'd0, ds};
        e.q = q64[31:0]; e.r = r64[31:0]; e.e = 1'b0; e.cyc = 32;
        sb.push_back(e);
    endtask

    task automatic check_pop(input string tag, input int cyc);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'(e.cyc));
        chk({tag, "_quotient"},    {32'd0, quotient},  {32'd0, e.q});
        chk({tag, "_remainder"},   {32'd0, remainder}, {32'd0, e.r});
        chk({tag, "_error"},       {63'd0, error},     {63'd0, e.e});
    endtask

    // Launch one operation; optionally pulse start again at busy cycle inj,
    // or assert reset at busy cycle rst_at (aborting the operation).
    task automatic run_op(input string tag, input logic [63:0] dd, input logic [31:0] ds,
                          input int inj, input int rst_at);
        int cyc;
        logic stray;
        @(negedge clk);
        start = 1'b1; dividend = dd; divisor = ds;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            start = (cyc == inj) ? 1'b1 : 1'b0;
            if (cyc == rst_at) begin
                reset = 1'b0;
                #1;
                chk({tag, "_rst_busy"}, {63'd0, busy},      64'd0);
                chk({tag, "_rst_quo"},  {32'd0, quotient},  64'd0);
                chk({tag, "_rst_rem"},  {32'd0, remainder}, 64'd0);
                chk({tag, "_rst_err"},  {63'd0, error},     64'd0);
                @(negedge clk);
                chk({tag, "_rst_hold"}, {63'd0, busy}, 64'd0);
                reset = 1'b1;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (cyc >= 100) chk({tag, "_timeout"}, 64'(cyc), 64'd32);
        check_pop(tag, cyc);
        if (inj > 0) begin
            stray = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (busy !== 1'b0) stray = 1'b1;
            end
            chk({tag, "_no_second_op"}, {63'd0, stray}, 64'd0);
        end
    endtask

    initial begin
        logic [31:0] ds;
        logic [31:0] hi;
        logic [63:0] dd;
        int cyc;

        reset = 1'b0; start = 1'b0; dividend = 64'd0; divisor = 32'd0;
        #1;
        chk("reset_busy", {63'd0, busy},      64'd0);
        chk("reset_quo",  {32'd0, quotient},  64'd0);
        chk("reset_rem",  {32'd0, remainder}, 64'd0);
        chk("reset_err",  {63'd0, error},     64'd0);
        #20;
        reset = 1'b1;

        // Known vector with a stray start mid-run.
        push_model(64'd70727782098404069, 32'd341312304);
        run_op("v024", 64'd70727782098404069, 32'd341312304, 6, 0);
        chk("v024_quo_const", {32'd0, quotient},  64'd207223066);
        chk("v024_rem_const", {32'd0, remainder}, 64'd5);

        push_model(64'd1901300, 32'd816);
        run_op("v025", 64'd1901300, 32'd816, 0, 0);
        chk("v025_quo_const", {32'd0, quotient}, 64'd2330);
        chk("v025_rem_const", {32'd0, remainder}, 64'd20);

        push_model(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
        run_op("v026", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 0, 0);
        chk("v026_quo_const", {32'd0, quotient}, 64'h0000_0000_FFFF_FFFF);

`ifdef DIV_ERR_CHECK_EN
        push_model(64'd12345, 32'd0);
        run_op("div0", 64'd12345, 32'd0, 0, 0);
        push_model(64'h1_0000_0000, 32'd1);
        run_op("ovf", 64'h1_0000_0000, 32'd1, 0, 0);
        push_model(64'd1901300, 32'd816);
        run_op("after_err", 64'd1901300, 32'd816, 0, 0);
`endif

        // Random valid operands (high half below divisor).
        for (int i = 0; i < 4; i++) begin
            ds = $urandom() | 32'd1;
            hi = $urandom() % ds;
            dd = {hi, 32'($urandom())};
            push_model(dd, ds);
            run_op("rand", dd, ds, 0, 0);
        end

        // Abort mid-run, then restart.
        run_op("abort", 64'd70727782098404069, 32'd341312304, 0, 10);
        push_model(64'd1901300, 32'd816);
        run_op("restart", 64'd1901300, 32'd816, 0, 0);

        // Start held high: second operation launches in the single IDLE cycle.
        push_model(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
        push_model(64'd1901300, 32'd816);
        @(negedge clk);
        start = 1'b1; dividend = 64'hFFFF_FFFE_0000_0001; divisor = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("b2b_first_busy", {63'd0, busy}, 64'd1);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        dividend = 64'd1901300; divisor = 32'd816;
        check_pop("b2b_a", cyc);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_restart_busy", {63'd0, busy}, 64'd1);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check_pop("b2b_b", cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
